// File: rtl/onehot_collector.sv
// onehot_collector: rebuilds a bit-vector mask from a stream of binary bit
// indices. Each accepted index is decoded to one-hot and OR-accumulated until
// a beat tagged last arrives. The mask, its population count and the
// duplicate/out-of-range flags are then offered on a val/rdy output stream.
// istream_rdy and ostream_val depend only on the state register, so there is
// no combinational path from any input to either handshake output.
module onehot_collector #(
  parameter  int p_width = 8,
  localparam int IW      = (p_width > 1) ? $clog2(p_width) : 1,
  localparam int CW      = $clog2(p_width + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [IW-1:0]      istream_idx,
  input  logic               istream_last,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_width-1:0] ostream_mask,
  output logic [CW-1:0]      ostream_count,
  output logic               ostream_dup,
  output logic               ostream_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_e;

  // p_width always fits in IW+1 bits, so the range check is a plain compare.
  localparam logic [IW:0] P_LIM = (IW + 1)'(p_width);

  state_e             state_q, state_d;
  logic [p_width-1:0] mask_q, mask_d;
  logic [CW-1:0]      count_q, count_d;
  logic               dup_q, dup_d;
  logic               err_q, err_d;

  logic [p_width-1:0] onehot;
  logic               idx_oor;
  logic               idx_hit;
  logic               in_fire;
  logic               out_fire;

  // Index decoder. An out-of-range index matches no bit, so it decodes to 0.
  for (genvar gi = 0; gi < p_width; gi++) begin : g_dec
    assign onehot[gi] = (istream_idx == IW'(gi));
  end

  assign idx_oor  = ({1'b0, istream_idx} >= P_LIM);
  assign idx_hit  = |(onehot & mask_q);
  assign in_fire  = istream_val && (state_q == ACCUM);
  assign out_fire = ostream_rdy && (state_q == SEND);

  // Next-state: accumulate accepted indices, hand the set over on last,
  // and clear everything once the consumer takes the mask.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    dup_d   = dup_q;
    err_d   = err_q;
    case (state_q)
      ACCUM: begin
        if (in_fire) begin
          if (idx_oor) begin
            err_d = 1'b1;
          end else if (idx_hit) begin
            dup_d = 1'b1;
          end else begin
            mask_d  = mask_q | onehot;
            count_d = count_q + CW'(1);
          end
          if (istream_last) begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (out_fire) begin
          mask_d  = '0;
          count_d = '0;
          dup_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers; an asynchronous reset drops any partial set silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign istream_rdy = (state_q == ACCUM);
  assign ostream_val = (state_q == SEND);

  // Payload reads zero whenever no mask is being offered.
  assign ostream_mask  = ostream_val ? mask_q  : '0;
  assign ostream_count = ostream_val ? count_q : '0;
  assign ostream_dup   = ostream_val & dup_q;
  assign ostream_err   = ostream_val & err_q;

endmodule

// File: doc/onehot_collector.md
Name: onehot_collector

Overview:
- Decoder-side counterpart of the lowest-set-bit priority encoder: rebuilds a bit-vector mask from a stream of binary bit indices.
- Each accepted index is decoded to one-hot and OR-accumulated until a beat tagged last arrives.
- The completed mask, its population count, and duplicate/out-of-range flags are then emitted on a val/rdy output stream.
- Used wherever a serialized grant/selection list must be turned back into a request vector.

Parameters:
- p_width, 8, mask width in bits (>= 1).
- Derived, not a port parameter: IW = max(1, $clog2(p_width)) is the index width; CW = $clog2(p_width+1) is the count width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- istream_val  input  1  index beat valid
- istream_rdy  output  1  collector can accept an index beat
- istream_idx  input  IW  bit index to set
- istream_last  input  1  final index of the current set
- ostream_val  output  1  completed mask valid
- ostream_rdy  input  1  consumer accepts mask
- ostream_mask  output  p_width  accumulated mask
- ostream_count  output  CW  number of distinct in-range bits set
- ostream_dup  output  1  at least one in-range index repeated in this set
- ostream_err  output  1  at least one index >= p_width in this set

Behaviour:
- Reset (rst==0, asynchronous):
  - state = ACCUM; internal mask, count, dup and err registers cleared.
  - istream_rdy = 1; ostream_val = 0; ostream_mask = 0; ostream_count = 0; ostream_dup = 0; ostream_err = 0.
  - Reset asserted mid-set discards the partial mask with no output beat.
- Transfer rule: a transfer occurs on a rising edge where val && rdy. Both streams follow this rule.
- Input stream valid-to-ready: istream_rdy depends only on state. There is no combinational path from any input to istream_rdy.
- Output stream: ostream_val depends only on state.
- State ACCUM:
  - istream_rdy = 1; ostream_val = 0.
  - On each accepted beat:
    - idx >= p_width: err <= 1; mask and count unchanged.
    - mask[idx] already 1: dup <= 1; mask and count unchanged.
    - Otherwise: mask[idx] <= 1; count <= count + 1.
  - If the accepted beat has istream_last = 1, the update above is still applied, then state <= SEND.
  - Without a valid beat, nothing changes.
- State SEND:
  - istream_rdy = 0; ostream_val = 1.
  - ostream_mask, ostream_count, ostream_dup and ostream_err are driven from the registers and held stable while ostream_rdy = 0.
  - On ostream_rdy = 1: mask, count, dup and err are cleared; state <= ACCUM.
- Output signals when ostream_val = 0: ostream_mask, ostream_count, ostream_dup and ostream_err read 0. Gate the outputs, or clear the registers on transfer.
- Latency: ostream_val rises in the cycle immediately after the last beat is accepted. The earliest next index beat is accepted in the cycle after the mask transfer. Minimum set period is N+1 cycles for N beats.
- Single-beat set: a beat with last = 1 as the first beat yields a one-hot mask (or 0 with err = 1 if out of range).
- Full mask: count saturates naturally at p_width. Further in-range indices are duplicates, so no count overflow is possible.
- Out-of-range indices: when p_width is a power of two, no index can be out of range. When p_width = 1, IW = 1 and idx = 1 is out of range.
- No combinational path from istream_* to ostream_*.

Test Plan:
- Reset then idle, p_width=8: 5 cycles, no val. Expect istream_rdy=1, ostream_val=0, all outputs 0.
- Basic set: indices 0, 3, 7 (last on 7), ostream_rdy=1. Expect ostream_val one cycle after the 7 transfer, mask=8'b1000_1001, count=3, dup=0, err=0. istream_rdy=1 on the following cycle.
- Duplicate plus backpressure: indices 2, 2, 5 (last), ostream_rdy held 0 for 4 cycles. Expect mask=8'b0010_0100, count=2, dup=1, outputs stable and istream_rdy=0 throughout the stall. Transfer when ostream_rdy rises.
- Out-of-range, p_width=5: indices 1, 6 (last). Expect mask=5'b00010, count=1, err=1, dup=0.
- Back-to-back sets: set A = {4} (last), set B = {0, 1} (last), istream_val held 1. Expect mask 8'b0001_0000 / count 1, then mask 8'b0000_0011 / count 2 with no carryover. Set B's first beat is accepted the cycle after A's output transfer.
- Reset mid-operation: accept indices 1, 6, assert rst=0 asynchronously between edges. Expect immediate istream_rdy=1, ostream_val=0. After release, the set {3} (last) yields mask=8'b0000_1000, count=1.
